// File: rtl/sync_event_arbiter.sv
// Synchronizes NUM_CH asynchronous event lines, detects their active edges, queues
// them as pending bits and offers them one at a time on a valid/ready port in round-robin order.
module sync_event_arbiter #(
    parameter int   NUM_CH      = 4,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0,
    localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] async_in,
    input  logic [NUM_CH-1:0] enable_mask,
    input  logic              clear_overflow,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam logic [NUM_CH-1:0] INACTIVE = {NUM_CH{RESET_VAL}};

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic              evt_valid_q, evt_valid_d;
    state_t            state_q, state_d;

    logic [NUM_CH-1:0] rise_s;
    logic [NUM_CH-1:0] edge_s;
    logic [NUM_CH-1:0] cand_s;
    logic [NUM_CH-1:0] grant_clr_s;
    logic [NUM_CH-1:0] ovf_set_s;
    logic [CH_W-1:0]   next_ptr_s;
    logic [CH_W-1:0]   search_start_s;
    logic [CH_W-1:0]   sel_s;
    logic              found_s;

    // Synchronizer chain plus the delayed copy of the last stage used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= INACTIVE;
            end
            prev_q <= INACTIVE;
        end else begin
            sync_q[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Active edge: last stage has left the inactive level while its delayed copy has not.
    always_comb begin
        rise_s = (sync_q[SYNC_STAGES-1] ^ INACTIVE) & ~(prev_q ^ INACTIVE);
        edge_s = rise_s & enable_mask;
        cand_s = pending_q & enable_mask;
    end

    // Pointer just past the channel currently offered, wrapping to zero.
    always_comb begin
        if (evt_ch_q == CH_W'(NUM_CH - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = evt_ch_q + CH_W'(1);
        end
    end

    // After a handshake the search restarts just past the accepted channel.
    always_comb begin
        if (state_q == ST_OFFER) begin
            search_start_s = next_ptr_s;
        end else begin
            search_start_s = rr_q;
        end
    end

    // First candidate at or after the search start, wrapping around.
    always_comb begin
        int            sum;
        logic [CH_W-1:0] idx;
        found_s = 1'b0;
        sel_s   = '0;
        sum     = 0;
        idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = int'(search_start_s) + k;
            idx = CH_W'((sum >= NUM_CH) ? (sum - NUM_CH) : sum);
            if (!found_s && cand_s[idx]) begin
                found_s = 1'b1;
                sel_s   = idx;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Offer FSM: loads a channel into the output register and clears its pending bit.
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_d        = rr_q;
        grant_clr_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    evt_ch_d           = sel_s;
                    evt_valid_d        = 1'b1;
                    grant_clr_s[sel_s] = 1'b1;
                    state_d            = ST_OFFER;
                end else begin
                    evt_valid_d = 1'b0;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    rr_d = next_ptr_s;
                    if (found_s) begin
                        evt_ch_d           = sel_s;
                        evt_valid_d        = 1'b1;
                        grant_clr_s[sel_s] = 1'b1;
                    end else begin
                        evt_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    evt_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    // A new edge re-arms a bit that is leaving for the output this cycle without counting as lost.
    always_comb begin
        ovf_set_s  = edge_s & pending_q & ~grant_clr_s;
        pending_d  = ((pending_q & ~grant_clr_s) | edge_s) & enable_mask;
        if (clear_overflow) begin
            overflow_d = ovf_set_s;
        end else begin
            overflow_d = overflow_q | ovf_set_s;
        end
    end

    // Event queue, scheduler and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            overflow_q  <= '0;
            rr_q        <= '0;
            evt_ch_q    <= '0;
            evt_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            rr_q        <= rr_d;
            evt_ch_q    <= evt_ch_d;
            evt_valid_q <= evt_valid_d;
            state_q     <= state_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// Randomized and directed bench for sync_event_arbiter: a cycle-level reference model
// feeds an expected-grant queue that an independent monitor drains on every handshake.
module tb_sync_event_arbiter;

    localparam int N = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] async_in;
    logic [N-1:0] enable_mask;
    logic         clear_overflow;
    logic         evt_ready;
    logic         evt_valid;
    logic [1:0]   evt_ch;
    logic [N-1:0] pending;
    logic [N-1:0] overflow;

    int total = 0;
    int bad   = 0;
    int grants = 0;

    int       exp_q[$];
    bit [N-1:0] m_hist[$];
    bit [N-1:0] m_pend;
    bit [N-1:0] m_ovf;
    int         m_rr;
    int         m_off;

    sync_event_arbiter #(.NUM_CH(N), .SYNC_STAGES(S), .RESET_VAL(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .async_in       (async_in),
        .enable_mask    (enable_mask),
        .clear_overflow (clear_overflow),
        .evt_ready      (evt_ready),
        .evt_valid      (evt_valid),
        .evt_ch         (evt_ch),
        .pending        (pending),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_ovf  = '0;
        m_rr   = 0;
        m_off  = -1;
        m_hist.delete();
        for (int i = 0; i < S + 1; i++) m_hist.push_back('0);
        exp_q.delete();
    endtask

    function automatic int pick(input bit [N-1:0] c, input int start);
        for (int k = 0; k < N; k++) begin
            if (c[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Reference model: compare current outputs, then advance through the coming posedge.
    always begin
        bit [N-1:0] last, prv, ev, np, set;
        int take;
        @(negedge clk);
        #3;
        if (!rst) begin
            total++;
            if (evt_valid !== (m_off >= 0) || (m_off >= 0 && evt_ch !== 2'(m_off)) ||
                pending !== m_pend || overflow !== m_ovf) begin
                bad++;
                $display("FAIL state t=%0t got v=%0b ch=%0d pend=%b ovf=%b want v=%0b ch=%0d pend=%b ovf=%b",
                         $time, evt_valid, evt_ch, pending, overflow, m_off >= 0, m_off, m_pend, m_ovf);
            end
            // synchronized level is the input sampled S-1 edges ago; rising vs the sample before it
            last = m_hist[m_hist.size() - S];
            prv  = m_hist[m_hist.size() - S - 1];
            ev   = last & ~prv & enable_mask;
            take = -1;
            if (m_off < 0) begin
                take  = pick(m_pend & enable_mask, m_rr);
                m_off = take;
            end else if (evt_ready) begin
                exp_q.push_back(m_off);
                m_rr  = (m_off + 1) % N;
                take  = pick(m_pend & enable_mask, m_rr);
                m_off = take;
            end
            set = '0;
            for (int i = 0; i < N; i++) begin
                if (i == take) begin
                    np[i] = ev[i];
                end else begin
                    if (ev[i] && m_pend[i]) set[i] = 1'b1;
                    np[i] = m_pend[i] | ev[i];
                end
            end
            m_pend = np & enable_mask;
            m_ovf  = (clear_overflow ? '0 : m_ovf) | set;
            m_hist.push_back(async_in);
            void'(m_hist.pop_front());
        end
    end

    // Monitor: every handshake must match the next expected grant.
    always begin
        int e;
        @(negedge clk);
        #4;
        if (!rst && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            grants++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL grant: got ch=%0d expected none at %0t", evt_ch, $time);
            end else begin
                e = exp_q.pop_front();
                if (evt_ch !== 2'(e)) begin
                    bad++;
                    $display("FAIL grant: got ch=%0d expected ch=%0d at %0t", evt_ch, e, $time);
                end
            end
        end
    end

    task automatic pulse(input logic [N-1:0] chans, input int gap);
        @(negedge clk);
        async_in = chans;
        @(negedge clk);
        async_in = '0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; async_in = '0; enable_mask = 4'hF; clear_overflow = 1'b0; evt_ready = 1'b0;
        model_reset();
        #1;
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_ch", int'(evt_ch), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // single edge on ch2: offered S+1 edges after the first sampling edge
        @(negedge clk);
        async_in[2] = 1'b1; evt_ready = 1'b1;
        @(posedge clk);
        repeat (S + 1) @(posedge clk);
        #1;
        chk("lat_valid", int'(evt_valid), 1);
        chk("lat_ch", int'(evt_ch), 2);
        @(posedge clk);
        #1;
        chk("lat_drop", int'(evt_valid), 0);
        @(negedge clk);
        async_in = '0;
        repeat (4) @(negedge clk);

        // simultaneous edges on 0,1,3
        pulse(4'b1011, 8);
        chk("burst_pending", int'(pending), 0);

        // ch0/ch1 re-pulsed every 4 cycles
        for (int r = 0; r < 6; r++) pulse(4'b0011, 2);
        repeat (6) @(negedge clk);

        // backpressure and overflow on ch1
        evt_ready = 1'b0;
        for (int r = 0; r < 3; r++) pulse(4'b0010, 2);
        repeat (4) @(negedge clk);
        chk("ovf_set", int'(overflow[1]), 1);
        chk("ovf_pend", int'(pending[1]), 1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("ovf_clear", int'(overflow), 0);
        evt_ready = 1'b1;
        repeat (6) @(negedge clk);

        // masked channel ignored, enabled channel served
        enable_mask = 4'b1011;
        pulse(4'b0100, 6);
        chk("mask_pending", int'(pending[2]), 0);
        chk("mask_valid", int'(evt_valid), 0);
        pulse(4'b1000, 6);
        enable_mask = 4'hF;

        // reset while an event is offered and another is pending
        evt_ready = 1'b0;
        pulse(4'b0011, 5);
        chk("pre_rst_valid", int'(evt_valid), 1);
        #1;
        rst = 1'b1; async_in = '0;
        model_reset();
        #1;
        chk("midrst_valid", int'(evt_valid), 0);
        chk("midrst_pending", int'(pending), 0);
        chk("midrst_overflow", int'(overflow), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) async_in[i] = ~async_in[i];
            end
            evt_ready      = ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) enable_mask = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 19) == 0) enable_mask = 4'hF;
        end
        @(negedge clk);
        async_in = '0; evt_ready = 1'b1; enable_mask = 4'hF; clear_overflow = 1'b0;
        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        total++;
        if (grants < 20) begin
            bad++;
            $display("FAIL activity: got %0d grants expected at least 20", grants);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
